// File: rtl/phy_reg_ready_scoreboard_pkg.sv
// Shared types and sizing for the physical-register ready scoreboard and its
// feedback producers.
package phy_reg_ready_scoreboard_pkg;

    localparam int PHY_REG_NUM  = 64;
    localparam int PHY_ID_WIDTH = $clog2(PHY_REG_NUM);
    localparam int DATA_WIDTH   = 32;

    localparam int ALU_UNIT_NUM = 2;
    localparam int BRU_UNIT_NUM = 1;
    localparam int CSR_UNIT_NUM = 1;
    localparam int DIV_UNIT_NUM = 1;
    localparam int LSU_UNIT_NUM = 1;
    localparam int MUL_UNIT_NUM = 1;
    localparam int EXECUTE_UNIT_NUM = ALU_UNIT_NUM + BRU_UNIT_NUM + CSR_UNIT_NUM +
                                      DIV_UNIT_NUM + LSU_UNIT_NUM + MUL_UNIT_NUM;

    localparam logic [PHY_ID_WIDTH-1:0] NULL_PHY_ID = {PHY_ID_WIDTH{1'b0}};

    typedef struct packed {
        logic                    enable;
        logic [PHY_ID_WIDTH-1:0] phy_id;
        logic [DATA_WIDTH-1:0]   value;
    } execute_feedback_channel_t;

    // Channel order: ALU..., BRU, CSR, DIV, LSU, MUL (index 0 is the first ALU).
    typedef execute_feedback_channel_t [EXECUTE_UNIT_NUM-1:0] execute_feedback_pack_t;

    // Number of registers whose ready bit is clear.
    function automatic logic [PHY_ID_WIDTH:0] count_busy(input logic [PHY_REG_NUM-1:0] ready);
        logic [PHY_ID_WIDTH:0] cnt;
        cnt = {(PHY_ID_WIDTH+1){1'b0}};
        for (int i = 0; i < PHY_REG_NUM; i++) begin
            cnt = cnt + {{PHY_ID_WIDTH{1'b0}}, ~ready[i]};
        end
        return cnt;
    endfunction

    function automatic execute_feedback_pack_t clear_enables(input execute_feedback_pack_t pack);
        execute_feedback_pack_t cleared;
        cleared = pack;
        for (int c = 0; c < EXECUTE_UNIT_NUM; c++) begin
            cleared[c].enable = 1'b0;
        end
        return cleared;
    endfunction

endpackage

// File: rtl/phy_reg_ready_scoreboard_feedback_match_mux.sv
// Finds the lowest-index enabled feedback channel carrying a given phy_id.
// Register 0 never matches.
module feedback_match_mux
    import phy_reg_ready_scoreboard_pkg::*;
(
    input  logic [PHY_ID_WIDTH-1:0] phy_id,
    input  execute_feedback_pack_t  pack,
    output logic                    hit,
    output logic [DATA_WIDTH-1:0]   value
);

    // Priority select: scanning downwards lets the lowest index land last.
    always_comb begin
        hit   = 1'b0;
        value = {DATA_WIDTH{1'b0}};
        for (int c = EXECUTE_UNIT_NUM - 1; c >= 0; c--) begin
            if (pack[c].enable && (pack[c].phy_id == phy_id) && (phy_id != NULL_PHY_ID)) begin
                hit   = 1'b1;
                value = pack[c].value;
            end else begin
                hit   = hit;
                value = value;
            end
        end
    end

endmodule

// File: rtl/phy_reg_ready_scoreboard.sv
// Per-physical-register ready scoreboard fed by the execute feedback pack.
// Optional bypass stage enabled by PHY_REG_READY_SCOREBOARD_BYPASS_EN.
module phy_reg_ready_scoreboard
    import phy_reg_ready_scoreboard_pkg::*;
#(
    parameter int ALLOC_PORT_NUM = 2,
    parameter int READ_PORT_NUM  = 4
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  execute_feedback_pack_t                       execute_feedback_pack,
    input  logic [ALLOC_PORT_NUM-1:0]                    alloc_valid,
    input  logic [ALLOC_PORT_NUM-1:0][PHY_ID_WIDTH-1:0]  alloc_phy_id,
    input  logic                                         flush,
    input  logic [READ_PORT_NUM-1:0][PHY_ID_WIDTH-1:0]   rd_phy_id,
    output logic [READ_PORT_NUM-1:0]                     rd_ready,
    output logic [READ_PORT_NUM-1:0]                     byp_valid,
    output logic [READ_PORT_NUM-1:0][DATA_WIDTH-1:0]     byp_value,
    output logic [PHY_ID_WIDTH:0]                        busy_count,
    output logic                                         dup_error
);

    logic [PHY_REG_NUM-1:0] ready_r;
    logic [PHY_REG_NUM-1:0] ready_next_s;
    logic                   dup_s;

    // Next ready vector: flush beats alloc, alloc beats feedback, register 0 pinned.
    always_comb begin
        ready_next_s = ready_r;
        if (flush) begin
            ready_next_s = {PHY_REG_NUM{1'b1}};
        end else begin
            for (int c = 0; c < EXECUTE_UNIT_NUM; c++) begin
                ready_next_s[execute_feedback_pack[c].phy_id] =
                    execute_feedback_pack[c].enable ? 1'b1
                                                    : ready_next_s[execute_feedback_pack[c].phy_id];
            end
            for (int k = 0; k < ALLOC_PORT_NUM; k++) begin
                ready_next_s[alloc_phy_id[k]] = alloc_valid[k] ? 1'b0 : ready_next_s[alloc_phy_id[k]];
            end
        end
        ready_next_s[0] = 1'b1;
    end

    // Two enabled channels naming the same nonzero register in one cycle.
    always_comb begin
        dup_s = 1'b0;
        for (int i = 0; i < EXECUTE_UNIT_NUM; i++) begin
            for (int j = i + 1; j < EXECUTE_UNIT_NUM; j++) begin
                dup_s = dup_s | (execute_feedback_pack[i].enable & execute_feedback_pack[j].enable &
                                 (execute_feedback_pack[i].phy_id == execute_feedback_pack[j].phy_id) &
                                 (execute_feedback_pack[i].phy_id != NULL_PHY_ID));
            end
        end
    end

    // Scoreboard state, busy count and sticky duplicate flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ready_r    <= {PHY_REG_NUM{1'b1}};
            busy_count <= {(PHY_ID_WIDTH+1){1'b0}};
            dup_error  <= 1'b0;
        end else begin
            ready_r    <= ready_next_s;
            busy_count <= count_busy(ready_next_s);
            dup_error  <= dup_error | dup_s;
        end
    end

`ifdef PHY_REG_READY_SCOREBOARD_BYPASS_EN
    execute_feedback_pack_t last_r;

    // One-deep copy of the feedback pack; a flush kills its enables.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_r <= '0;
        end else if (flush) begin
            last_r <= clear_enables(execute_feedback_pack);
        end else begin
            last_r <= execute_feedback_pack;
        end
    end
`endif

    for (genvar p = 0; p < READ_PORT_NUM; p++) begin : g_rd
        logic                  cur_hit_s;
        logic [DATA_WIDTH-1:0] cur_value_s;

        feedback_match_mux u_cur_match (
            .phy_id (rd_phy_id[p]),
            .pack   (execute_feedback_pack),
            .hit    (cur_hit_s),
            .value  (cur_value_s)
        );

        // Queries see this cycle's feedback but never this cycle's allocations.
        assign rd_ready[p] = ready_r[rd_phy_id[p]] | cur_hit_s;

`ifdef PHY_REG_READY_SCOREBOARD_BYPASS_EN
        logic                  last_hit_s;
        logic [DATA_WIDTH-1:0] last_value_s;

        feedback_match_mux u_last_match (
            .phy_id (rd_phy_id[p]),
            .pack   (last_r),
            .hit    (last_hit_s),
            .value  (last_value_s)
        );

        assign byp_valid[p] = cur_hit_s | last_hit_s;
        assign byp_value[p] = cur_hit_s  ? cur_value_s  :
                              last_hit_s ? last_value_s : {DATA_WIDTH{1'b0}};
`else
        logic unused_value_s;
        assign unused_value_s = ^cur_value_s;
        assign byp_valid[p]   = 1'b0;
        assign byp_value[p]   = {DATA_WIDTH{1'b0}};
`endif
    end

endmodule
